// File: rtl/mac_fifo_pkg.sv
// Shared types and default sizing for the MAC result FIFO.
// Pure declarations; no logic, no latency.
// No flow control at this level.
package mac_fifo_pkg;
    localparam int DATA_W     = 32;
    localparam int DEPTH_DEF  = 8;
    localparam int DROP_W_DEF = 16;

    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/mac_fifo_mem.sv
// DEPTH x word_t storage: one synchronous write port, one asynchronous read port.
// Write lands at posedge; read data follows raddr_i combinationally.
// No backpressure; the caller guarantees writes only target free slots.
module mac_fifo_mem
    import mac_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    word_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mac_result_fifo.sv
// FWFT result buffer behind the a*b+c stage; optional max tracker under MAC_FIFO_STATS_EN.
// Latency: a word pushed into an empty FIFO is on data_out right after the push edge.
// Backpressure: consumer valid/ready; producer cannot stall, so writes to a full FIFO are dropped and counted.
module mac_result_fifo
    import mac_fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     validi,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     readyi,
    output logic                     valido,
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    input  logic                     clr_ovf
`ifdef MAC_FIFO_STATS_EN
    ,
    output logic [DATA_W-1:0]        max_seen
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] rd_data;
    logic              push, pop, drop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign valido   = !empty;
    assign data_out = empty ? '0 : rd_data;

    assign pop  = valido & readyi;
    assign push = validi & (!full | pop);
    assign drop = validi & full & !pop;

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    mac_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_data)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (clr_ovf) begin
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end
        // A drop in the clearing cycle still counts, so the clear never hides it.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = DROP_W'(1);
            end else if (!(&drop_cnt_q)) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef MAC_FIFO_STATS_EN
    logic [DATA_W-1:0] max_seen_q, max_seen_d;

    always_comb begin
        max_seen_d = max_seen_q;
        if (push) begin
            max_seen_d = (clr_ovf || (data_in > max_seen_q)) ? data_in : max_seen_q;
        end else if (clr_ovf) begin
            max_seen_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_seen_q <= '0;
        end else begin
            max_seen_q <= max_seen_d;
        end
    end

    assign max_seen = max_seen_q;
`endif

endmodule

// File: tb/tb_mac_result_fifo.sv
// Scoreboard bench for mac_result_fifo: queue-based reference model plus output monitor.
// Inputs change 1 ns after posedge; outputs are checked after posedge and at negedge.
// DROP_W is reduced so drop-counter saturation is reachable in a short run.
module tb_mac_result_fifo;
    import mac_fifo_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 4;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int DMAX   = (1 << DROP_W) - 1;

    logic              clk;
    logic              rst;
    logic              validi;
    logic [31:0]       data_in;
    logic              readyi;
    logic              valido;
    logic [31:0]       data_out;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    logic              clr_ovf;
`ifdef MAC_FIFO_STATS_EN
    logic [31:0]       max_seen;
`endif

    mac_result_fifo #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .validi   (validi),
        .data_in  (data_in),
        .readyi   (readyi),
        .valido   (valido),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
`ifdef MAC_FIFO_STATS_EN
        ,
        .max_seen (max_seen)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [31:0] sb [$];
    int          mcount;
    int          mdrop;
    bit          movf;
    logic [31:0] mmax;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mcount = 0;
        mdrop  = 0;
        movf   = 0;
        mmax   = '0;
    endtask

    task automatic check_status();
        chk("count", 32'(count), mcount);
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("full", 32'(full), 32'(mcount == DEPTH));
        chk("valido", 32'(valido), 32'(mcount != 0));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("drop_cnt", 32'(drop_cnt), mdrop);
        if (mcount == 0) chk("data_out_empty", data_out, 32'd0);
`ifdef MAC_FIFO_STATS_EN
        chk("max_seen", max_seen, mmax);
`endif
    endtask

    // One clock of stimulus; the model advances by the rules for this cycle.
    task automatic cyc(input bit v, input logic [31:0] d, input bit r, input bit c);
        bit pop_m, full_m, push_m, drop_m;
        validi  = v;
        data_in = d;
        readyi  = r;
        clr_ovf = c;
        pop_m  = (mcount > 0) && r;
        full_m = (mcount == DEPTH);
        push_m = v && (!full_m || pop_m);
        drop_m = v && full_m && !pop_m;
        if (push_m) sb.push_back(d);
        mcount = mcount + int'(push_m) - int'(pop_m);
        if (drop_m) begin
            movf  = 1;
            mdrop = c ? 1 : ((mdrop < DMAX) ? mdrop + 1 : DMAX);
        end else if (c) begin
            movf  = 0;
            mdrop = 0;
        end
        if (push_m) mmax = c ? d : ((d > mmax) ? d : mmax);
        else if (c) mmax = '0;
        @(posedge clk);
        #1;
        check_status();
    endtask

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && valido && readyi) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop actual=%0h expected=none", data_out);
                end else begin
                    e = sb.pop_front();
                    chk("data_out", data_out, e);
                end
            end
        end
    end

    initial begin : stim
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        validi  = 1'b0;
        data_in = '0;
        readyi  = 1'b0;
        clr_ovf = 1'b0;
        model_reset();
        #12;
        check_status();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Pass-through with a ready consumer: occupancy never exceeds one.
        cyc(1, 32'd5, 1, 0);
        cyc(1, 32'd7, 1, 0);
        cyc(1, 32'd9, 1, 0);
        cyc(0, 32'd0, 1, 0);

        // Fill, drop one, then write into a full FIFO while popping.
        for (int i = 1; i <= DEPTH; i++) cyc(1, 32'(i), 0, 0);
        cyc(1, 32'd99, 0, 0);
        cyc(1, 32'd42, 1, 0);
        repeat (DEPTH + 1) cyc(0, 32'd0, 1, 0);

        // Saturate the drop counter, then clear together with and without a drop.
        for (int i = 0; i < DEPTH; i++) cyc(1, $urandom, 0, 0);
        repeat (DMAX + 3) cyc(1, $urandom, 0, 0);
        cyc(1, 32'd5, 0, 1);
        cyc(0, 32'd0, 0, 1);
        repeat (DEPTH) cyc(0, 32'd0, 1, 0);

        // Asynchronous reset between edges with words buffered.
        repeat (3) cyc(1, 32'd11, 0, 0);
        validi = 1'b0;
        rst    = 1'b0;
        #1;
        chk("rst_valido", 32'(valido), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_status();

        // Max tracking sequence (only observed when the stats build is enabled).
        cyc(1, 32'd10, 0, 0);
        cyc(1, 32'd300, 0, 0);
        cyc(1, 32'd20, 0, 0);
        cyc(0, 32'd0, 0, 1);
        cyc(1, 32'd4, 0, 0);
        repeat (DEPTH) cyc(0, 32'd0, 1, 0);

        // Randomized traffic with varying consumer throughput.
        for (int ph = 0; ph < 3; ph++) begin
            repeat (1000) begin
                cyc($urandom_range(0, 3) != 0, $urandom,
                    $urandom_range(0, 3) < 32'(ph + 1), $urandom_range(0, 40) == 0);
            end
        end

        repeat (DEPTH + 2) cyc(0, 32'd0, 1, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
